// File: rtl/audio_pkg.sv
// Shared types for the SRAM record/playback engine.
// State encoding, sample-half index and capacity helper.
package audio_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REC_WAIT  = 3'd1,
    S_REC_WR_L  = 3'd2,
    S_REC_WR_R  = 3'd3,
    S_PLAY_RD_L = 3'd4,
    S_PLAY_RD_R = 3'd5,
    S_PLAY_CAP  = 3'd6,
    S_PLAY_HOLD = 3'd7
  } state_e;

  localparam logic HALF_L = 1'b0;
  localparam logic HALF_R = 1'b1;

  // Each stereo sample takes two SRAM words.
  function automatic int unsigned max_samples(input int unsigned aw);
    return 32'd1 << (aw - 1);
  endfunction

endpackage

// File: rtl/audio_sram_recplay.sv
// Record/playback engine: stereo stream <-> 16-bit SRAM.
// Start/stop strobes from the top-level control FSM.
module audio_sram_recplay
  import audio_pkg::*;
#(
  parameter int ADDR_W = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start_rec,
  input  logic              i_start_play,
  input  logic              i_stop,
  output logic              o_record_audio_ready,
  input  logic [31:0]       i_record_audio_data,
  input  logic              i_record_audio_valid,
  output logic              o_play_audio_valid,
  output logic [31:0]       o_play_audio_data,
  input  logic              i_play_audio_ready,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_wdata,
  output logic              o_sram_we,
  input  logic [15:0]       i_sram_rdata,
  output logic [ADDR_W-1:0] o_rec_len,
  output logic              o_done,
  output logic              o_full,
  output logic [2:0]        o_state
);

  localparam int PW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] MAX_N =
    ADDR_W'(max_samples(ADDR_W));

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [31:0]       data_q, data_d;
  logic              rdy_q, rdy_d;
  logic              vld_q, vld_d;
  logic              done_q, done_d;
  logic              full_q, full_d;

  logic [PW-1:0]     ptr_inc;
  logic [ADDR_W-1:0] cnt_inc;

  assign ptr_inc = ptr_q + 1'b1;
  assign cnt_inc = {1'b0, ptr_q} + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    data_d  = data_q;
    done_d  = 1'b0;
    full_d  = 1'b0;
    if (state_q != S_IDLE && i_stop) begin
      // Abort drops any half-written sample from the count.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_stop) begin
            state_d = S_IDLE;
          end else if (i_start_rec) begin
            ptr_d   = '0;
            len_d   = '0;
            state_d = S_REC_WAIT;
          end else if (i_start_play) begin
            ptr_d = '0;
            if (len_q == '0) done_d = 1'b1;
            else state_d = S_PLAY_RD_L;
          end
        end
        S_REC_WAIT: begin
          if (i_record_audio_valid) begin
            data_d  = i_record_audio_data;
            state_d = S_REC_WR_L;
          end
        end
        S_REC_WR_L: state_d = S_REC_WR_R;
        S_REC_WR_R: begin
          ptr_d = ptr_inc;
          len_d = cnt_inc;
          if (cnt_inc == MAX_N) begin
            full_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_REC_WAIT;
          end
        end
        S_PLAY_RD_L: state_d = S_PLAY_RD_R;
        S_PLAY_RD_R: begin
          data_d[31:16] = i_sram_rdata;
          state_d       = S_PLAY_CAP;
        end
        S_PLAY_CAP: begin
          data_d[15:0] = i_sram_rdata;
          state_d      = S_PLAY_HOLD;
        end
        S_PLAY_HOLD: begin
          if (i_play_audio_ready) begin
            ptr_d = ptr_inc;
            if (cnt_inc == len_q) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_PLAY_RD_L;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    rdy_d = (state_d == S_REC_WAIT);
    vld_d = (state_d == S_PLAY_HOLD);
  end

  always_comb begin
    o_sram_addr  = '0;
    o_sram_wdata = '0;
    o_sram_we    = 1'b0;
    unique case (state_q)
      S_REC_WR_L: begin
        o_sram_addr  = {ptr_q, HALF_L};
        o_sram_wdata = data_q[31:16];
        o_sram_we    = 1'b1;
      end
      S_REC_WR_R: begin
        o_sram_addr  = {ptr_q, HALF_R};
        o_sram_wdata = data_q[15:0];
        o_sram_we    = 1'b1;
      end
      S_PLAY_RD_L: o_sram_addr = {ptr_q, HALF_L};
      S_PLAY_RD_R: o_sram_addr = {ptr_q, HALF_R};
      default: ;
    endcase
  end

  assign o_record_audio_ready = rdy_q;
  assign o_play_audio_valid   = vld_q;
  assign o_play_audio_data    = data_q;
  assign o_rec_len            = len_q;
  assign o_done               = done_q;
  assign o_full               = full_q;
  assign o_state              = state_q;

endmodule

// File: tb/tb_audio_sram_recplay.sv
// Scoreboard bench for audio_sram_recplay with a small SRAM model.
// Small ADDR_W so the capacity boundary is reachable.
module tb_audio_sram_recplay;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_rec = 1'b0;
  logic          start_play = 1'b0;
  logic          stop = 1'b0;
  logic          rec_rdy;
  logic [31:0]   rec_data = '0;
  logic          rec_vld = 1'b0;
  logic          play_vld;
  logic [31:0]   play_data;
  logic          play_rdy = 1'b0;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic          sram_we;
  logic [15:0]   sram_rdata = '0;
  logic [AW-1:0] rec_len;
  logic          done;
  logic          full;
  logic [2:0]    state;

  audio_sram_recplay #(.ADDR_W(AW)) dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_start_rec          (start_rec),
    .i_start_play         (start_play),
    .i_stop               (stop),
    .o_record_audio_ready (rec_rdy),
    .i_record_audio_data  (rec_data),
    .i_record_audio_valid (rec_vld),
    .o_play_audio_valid   (play_vld),
    .o_play_audio_data    (play_data),
    .i_play_audio_ready   (play_rdy),
    .o_sram_addr          (sram_addr),
    .o_sram_wdata         (sram_wdata),
    .o_sram_we            (sram_we),
    .i_sram_rdata         (sram_rdata),
    .o_rec_len            (rec_len),
    .o_done               (done),
    .o_full               (full),
    .o_state              (state)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  logic [31:0] exp_wr [$];
  logic [31:0] exp_play [$];
  int          exp_done = 0;
  int          exp_full = 0;
  int          we_cnt = 0;
  logic        vld_prev = 1'b0;
  logic [31:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      vld_prev <= 1'b0;
    end else begin
      if (sram_we) begin
        we_cnt <= we_cnt + 1;
        if (exp_wr.size() == 0)
          chk("wr_unexp", 32'(sram_we), 32'd0);
        else
          chk("sram_wr", 32'({sram_addr, sram_wdata}),
              exp_wr.pop_front());
      end
      if (play_vld && !vld_prev) begin
        if (exp_play.size() == 0) begin
          chk("play_unexp", 32'(play_vld), 32'd0);
        end else begin
          held <= exp_play[0];
          chk("play_data", play_data, exp_play.pop_front());
        end
      end else if (play_vld) begin
        chk("play_hold", play_data, held);
      end
      if (done) begin
        if (exp_done == 0) chk("done_unexp", 32'(done), 32'd0);
        else exp_done <= exp_done - 1;
      end
      if (full) begin
        if (exp_full == 0) chk("full_unexp", 32'(full), 32'd0);
        else exp_full <= exp_full - 1;
      end
      vld_prev <= play_vld;
    end
  end

  task automatic wait_rdy();
    int n = 0;
    @(negedge clk);
    while (!rec_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", 32'(rec_rdy), 32'd1);
  endtask

  task automatic wait_vld();
    int n = 0;
    @(negedge clk);
    while (!play_vld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("vld_wait", 32'(play_vld), 32'd1);
  endtask

  task automatic send(input logic [31:0] d);
    wait_rdy();
    rec_vld  = 1'b1;
    rec_data = d;
    @(posedge clk);
    #1 rec_vld = 1'b0;
  endtask

  task automatic accept();
    repeat (10) @(negedge clk);
    play_rdy = 1'b1;
    @(posedge clk);
    #1 play_rdy = 1'b0;
  endtask

  task automatic strobe(input int which);
    @(negedge clk);
    case (which)
      0: start_rec = 1'b1;
      1: start_play = 1'b1;
      default: stop = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start_rec  = 1'b0;
    start_play = 1'b0;
    stop       = 1'b0;
  endtask

  task automatic push_rec(input logic [31:0] s, input int idx);
    exp_wr.push_back(32'({4'(2*idx), s[31:16]}));
    exp_wr.push_back(32'({4'(2*idx+1), s[15:0]}));
  endtask

  logic [31:0] smp [3] = '{32'h1111_2222, 32'h3333_4444,
                           32'h5555_6666};

  initial begin
    logic seen;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rdy", 32'(rec_rdy), 32'd0);
    chk("rst_len", 32'(rec_len), 32'd0);
    chk("rst_we", 32'(sram_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // both starts together: record wins
    for (int i = 0; i < 3; i++) push_rec(smp[i], i);
    @(negedge clk);
    start_rec  = 1'b1;
    start_play = 1'b1;
    @(posedge clk);
    #1;
    start_rec  = 1'b0;
    start_play = 1'b0;
    chk("both_start_state", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) send(smp[i]);
    repeat (3) @(negedge clk);
    chk("we_count", 32'(we_cnt), 32'd6);
    chk("rec_len3", 32'(rec_len), 32'd3);
    strobe(2);
    chk("rec_stop_state", 32'(state), 32'd0);
    chk("wr_left", 32'(exp_wr.size()), 32'd0);

    // full playback
    for (int i = 0; i < 3; i++) exp_play.push_back(smp[i]);
    exp_done = 1;
    strobe(1);
    for (int k = 0; k < 3; k++) begin
      wait_vld();
      accept();
    end
    repeat (5) @(negedge clk);
    chk("play_left", 32'(exp_play.size()), 32'd0);
    chk("done_left", 32'(exp_done), 32'd0);
    chk("play_end_state", 32'(state), 32'd0);

    // stop while holding sample 1
    exp_play.push_back(smp[0]);
    exp_play.push_back(smp[1]);
    strobe(1);
    wait_vld();
    accept();
    wait_vld();
    repeat (2) @(negedge clk);
    strobe(2);
    chk("stop_vld", 32'(play_vld), 32'd0);
    chk("stop_state", 32'(state), 32'd0);
    repeat (5) @(negedge clk);
    chk("stop_len", 32'(rec_len), 32'd3);
    chk("stop_play_left", 32'(exp_play.size()), 32'd0);

    // capacity: 9 offered, 8 stored
    strobe(0);
    for (int i = 0; i < 8; i++)
      push_rec({16'hA000 + 16'(i), 16'hB000 + 16'(i)}, i);
    exp_full = 1;
    for (int i = 0; i < 8; i++)
      send({16'hA000 + 16'(i), 16'hB000 + 16'(i)});
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | rec_rdy;
    end
    chk("full_rdy_low", 32'(seen), 32'd0);
    @(negedge clk);
    rec_vld  = 1'b1;
    rec_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 rec_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("full_len", 32'(rec_len), 32'd8);
    chk("full_state", 32'(state), 32'd0);
    chk("full_left", 32'(exp_full), 32'd0);
    chk("full_wr_left", 32'(exp_wr.size()), 32'd0);

    // empty recording then play
    strobe(0);
    strobe(2);
    chk("empty_len", 32'(rec_len), 32'd0);
    exp_done = 1;
    strobe(1);
    chk("empty_done", 32'(done), 32'd1);
    repeat (5) @(negedge clk);
    chk("empty_state", 32'(state), 32'd0);
    chk("empty_done_left", 32'(exp_done), 32'd0);

    // reset during the left-word write
    strobe(0);
    push_rec(32'h1234_5678, 0);
    send(32'h1234_5678);
    wait_rdy();
    rec_vld  = 1'b1;
    rec_data = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 rec_vld = 1'b0;
    chk("pre_rst_state", 32'(state), 32'd2);
    chk("pre_rst_len", 32'(rec_len), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_we", 32'(sram_we), 32'd0);
    chk("arst_addr", 32'(sram_addr), 32'd0);
    chk("arst_wdata", 32'(sram_wdata), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_len", 32'(rec_len), 32'd0);
    chk("arst_rdy", 32'(rec_rdy), 32'd0);
    chk("arst_vld", 32'(play_vld), 32'd0);
    chk("arst_data", play_data, 32'd0);
    chk("arst_flags", 32'({done, full}), 32'd0);
    chk("rst_wr_left", 32'(exp_wr.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
